wb_dsp_scoreboard: RTL and testbench
====================================

Name: wb_dsp_scoreboard

Overview:
- Synthesisable, parametrised self-checking scoreboard for the wb_dsp benches.
- Expected values are queued per channel; measured values are compared in order as they arrive.
- Counts tests and errors, runs a stall watchdog, and raises sticky pass/fail flags.
- Sits beside the DUT in every bench; the same block can also be instantiated in FPGA builds for on-chip self-test.

Parameters:
- NUM_CH, 4, number of independent compare channels (1..16).
- DATA_W, 32, compared data width.
- DEPTH, 8, expected-value FIFO depth per channel; power of two, ≥2.
- CNT_W, 16, width of test/error counters.
- TIMEOUT, 50000, cycles without a compare in RUN before watchdog failure; 0 disables the watchdog.

Ports:
- wb_clk  in  1  system clock; all logic on the rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: clear counters and FIFOs, enter RUN.
- done  in  1  pulse: stimulus finished, evaluate the verdict.
- exp_tests  in  CNT_W  required number of compares.
- exp_valid  in  1  push expected value.
- exp_ch  in  $clog2(NUM_CH)  expected channel.
- exp_data  in  DATA_W  expected value.
- meas_valid  in  1  measured value present.
- meas_ch  in  $clog2(NUM_CH)  measured channel.
- meas_data  in  DATA_W  measured value.
- cmp_valid  out  1  compare-result strobe.
- cmp_pass  out  1  result of the strobed compare.
- cmp_ch  out  $clog2(NUM_CH)  channel of the compare.
- cmp_exp  out  DATA_W  expected operand of the compare.
- cmp_meas  out  DATA_W  measured operand of the compare.
- test_count  out  CNT_W  compares performed.
- err_count  out  CNT_W  mismatches plus protocol errors.
- busy  out  1  high in RUN.
- test_passed  out  1  sticky pass flag.
- test_failed  out  1  sticky fail flag.

Behaviour:
- Reset: all outputs 0, all FIFOs empty, FSM in IDLE. Reset asserted mid-run aborts immediately with no verdict.
- FSM states: IDLE, RUN, PASS, FAIL.
  - IDLE -> RUN on start.
  - RUN -> PASS on done when test_count==exp_tests, err_count==0 and every FIFO is empty.
  - RUN -> FAIL on done otherwise, on watchdog expiry, or on any protocol error.
  - PASS and FAIL are terminal; start re-enters RUN and clears counters, FIFOs and flags in the same cycle.
  - exp/meas inputs are ignored outside RUN.
- Expected FIFO:
  - In RUN, exp_valid pushes exp_data into FIFO[exp_ch].
  - Push while full: value dropped, err_count+1, FIFO unchanged.
- Compare:
  - In RUN, meas_valid with FIFO[meas_ch] non-empty pops the head.
  - One cycle later: cmp_valid=1, cmp_pass=(head==meas_data), operands and channel registered. Latency is exactly 1.
  - test_count+1 on every compare; err_count+1 on a mismatch.
- Unexpected measurement: meas_valid with FIFO[meas_ch] empty gives cmp_valid=1, cmp_pass=0, cmp_exp=0, err_count+1; test_count is unchanged.
- Same-cycle push and pop:
  - Same channel, FIFO empty: the pushed value is not visible; the measurement is unexpected.
  - Same channel, FIFO non-empty: push and pop both occur; occupancy is unchanged; a full FIFO accepts the push.
- Protocol errors (FIFO overflow, unexpected measurement) force FAIL on the following cycle.
- Counters saturate at all-ones.
- Watchdog:
  - Counts in RUN and clears on any cmp_valid.
  - When it reaches TIMEOUT: FAIL.
- done and a protocol error in the same cycle: FAIL wins.
- test_passed and test_failed are mutually exclusive and held until start or wb_rst.

Optional Feature:
- WB_DSP_SCOREBOARD_MASK_EN defined:
  - Adds input exp_mask [DATA_W-1:0], stored alongside each expected entry.
  - Compare is ((head ^ meas_data) & mask)==0.
- Undefined: no mask port; full-width compare.

Decomposition:
- Shared package wb_dsp_scoreboard_pkg:
  - FSM state enum.
  - Error-cause codes (MISMATCH, OVERFLOW, UNEXPECTED, TIMEOUT).
  - Channel-index width function.
- Sub-module scoreboard_fifo:
  - Single-clock synchronous FIFO with full/empty flags, parametrised on width and depth.
  - Instantiated NUM_CH times via generate.

Test Plan:
- start; push 0xDEADBEEF on ch0; meas 0xDEADBEEF ch0; exp_tests=1; done -> cmp_pass=1 one cycle after meas, test_count=1, test_passed=1.
- Push 0x1 ch2; meas 0x2 ch2; done -> cmp_pass=0, cmp_exp=0x1, cmp_meas=0x2, err_count=1, test_failed=1.
- Push 0xA, 0xB on ch1 and 0xC on ch3; meas ch3=0xC, ch1=0xA, ch1=0xB; exp_tests=3 -> per-channel order kept, PASS.
- Push 9 values on ch0 with DEPTH=8 -> err_count=1, test_failed=1 on the cycle after the 9th push.
- TIMEOUT=100; start with no traffic -> test_failed=1 at cycle 100.
- wb_rst pulsed mid-RUN with 3 entries queued -> all outputs 0, IDLE; a new start behaves as fresh.

Source files
------------

// File: rtl/wb_dsp_scoreboard_pkg.sv
// Shared types for the wb_dsp scoreboard: FSM states, error-cause codes and
// the channel-index width helper used to size channel ports.
package wb_dsp_scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } sb_state_t;

  typedef enum logic [1:0] {
    ERR_MISMATCH   = 2'd0,
    ERR_OVERFLOW   = 2'd1,
    ERR_UNEXPECTED = 2'd2,
    ERR_TIMEOUT    = 2'd3
  } err_cause_t;

  // A single channel still needs a 1-bit index port.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_dsp_scoreboard_fifo.sv
// Single-clock expected-value FIFO. A push into a full FIFO is accepted only
// when a pop happens in the same cycle, so occupancy stays at DEPTH.
module scoreboard_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !rst && !clr;
  assign do_push = push && (!full || do_pop) && !rst && !clr;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/wb_dsp_scoreboard.sv
// Self-checking scoreboard: per-channel expected FIFOs, in-order compare with
// 1-cycle result latency, saturating counters, stall watchdog, sticky verdict.
// Optional per-entry compare mask: define WB_DSP_SCOREBOARD_MASK_EN.
module wb_dsp_scoreboard
  import wb_dsp_scoreboard_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int DATA_W  = 32,
  parameter  int DEPTH   = 8,
  parameter  int CNT_W   = 16,
  parameter  int TIMEOUT = 50000,
  localparam int CH_W    = ch_w(NUM_CH)
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              start,
  input  logic              done,
  input  logic [CNT_W-1:0]  exp_tests,
  input  logic              exp_valid,
  input  logic [CH_W-1:0]   exp_ch,
  input  logic [DATA_W-1:0] exp_data,
`ifdef WB_DSP_SCOREBOARD_MASK_EN
  input  logic [DATA_W-1:0] exp_mask,
`endif
  input  logic              meas_valid,
  input  logic [CH_W-1:0]   meas_ch,
  input  logic [DATA_W-1:0] meas_data,
  output logic              cmp_valid,
  output logic              cmp_pass,
  output logic [CH_W-1:0]   cmp_ch,
  output logic [DATA_W-1:0] cmp_exp,
  output logic [DATA_W-1:0] cmp_meas,
  output logic [CNT_W-1:0]  test_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy,
  output logic              test_passed,
  output logic              test_failed,
  output logic [1:0]        fsm_state
);

`ifdef WB_DSP_SCOREBOARD_MASK_EN
  localparam int FW = 2 * DATA_W;
`else
  localparam int FW = DATA_W;
`endif
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  sb_state_t         state, state_nxt;
  logic              active;
  logic [NUM_CH-1:0] fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_rdata [NUM_CH];
  logic [FW-1:0]     push_word, head_word;
  logic [DATA_W-1:0] head_data;
  logic              pop_ok, unexpected, overflow, proto_err, match, verdict_ok;
  logic [1:0]        err_inc;
  logic [CNT_W:0]    err_sum;
  logic [CNT_W-1:0]  err_nxt, test_nxt;
  logic [WD_W-1:0]   wd_cnt;
  logic              wd_expire;

  // start has priority: traffic in the start cycle is dropped with the clear.
  assign active     = (state == ST_RUN) && !start;
  assign head_word  = fifo_rdata[meas_ch];
  assign head_data  = head_word[DATA_W-1:0];
  assign pop_ok     = active && meas_valid && !fifo_empty[meas_ch];
  assign unexpected = active && meas_valid && fifo_empty[meas_ch];
  assign overflow   = active && exp_valid && fifo_full[exp_ch] &&
                      !(pop_ok && (meas_ch == exp_ch));
  assign proto_err  = overflow || unexpected;

`ifdef WB_DSP_SCOREBOARD_MASK_EN
  assign push_word = {exp_mask, exp_data};
  assign match     = ((head_data ^ meas_data) & head_word[FW-1:DATA_W]) == '0;
`else
  assign push_word = exp_data;
  assign match     = (head_data == meas_data);
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
    scoreboard_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
      .clk   (wb_clk),
      .rst   (wb_rst),
      .clr   (start),
      .push  (active && exp_valid && (exp_ch == CH_W'(c))),
      .pop   (pop_ok && (meas_ch == CH_W'(c))),
      .wdata (push_word),
      .rdata (fifo_rdata[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
  end

  // Overflow can coincide with a mismatch or unexpected measurement, so the
  // error counter may advance by two in one cycle.
  always_comb begin
    err_inc  = {1'b0, overflow} + {1'b0, unexpected} + {1'b0, pop_ok && !match};
    err_sum  = {1'b0, err_count} + {{(CNT_W-1){1'b0}}, err_inc};
    err_nxt  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    test_nxt = (pop_ok && (test_count != '1)) ? test_count + CNT_W'(1) : test_count;
  end

  assign wd_expire  = (TIMEOUT > 0) && (state == ST_RUN) && !cmp_valid &&
                      (wd_cnt == WD_W'(TIMEOUT - 1));
  assign verdict_ok = (test_nxt == exp_tests) && (err_nxt == '0) && (&fifo_empty);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_PASS, ST_FAIL: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (start)                       state_nxt = ST_RUN;
        else if (proto_err || wd_expire) state_nxt = ST_FAIL;
        else if (done)                   state_nxt = verdict_ok ? ST_PASS : ST_FAIL;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state      <= ST_IDLE;
      cmp_valid  <= 1'b0;
      cmp_pass   <= 1'b0;
      cmp_ch     <= '0;
      cmp_exp    <= '0;
      cmp_meas   <= '0;
      test_count <= '0;
      err_count  <= '0;
      wd_cnt     <= '0;
    end else begin
      state     <= state_nxt;
      cmp_valid <= pop_ok || unexpected;
      if (pop_ok || unexpected) begin
        cmp_pass <= pop_ok && match;
        cmp_ch   <= meas_ch;
        cmp_exp  <= pop_ok ? head_data : '0;
        cmp_meas <= meas_data;
      end
      if (start) begin
        test_count <= '0;
        err_count  <= '0;
        wd_cnt     <= '0;
      end else begin
        test_count <= test_nxt;
        err_count  <= err_nxt;
        if (state == ST_RUN) wd_cnt <= cmp_valid ? '0 : wd_cnt + WD_W'(1);
      end
    end
  end

  assign busy        = (state == ST_RUN);
  assign test_passed = (state == ST_PASS);
  assign test_failed = (state == ST_FAIL);
  assign fsm_state   = state;

endmodule

// File: tb/tb_wb_dsp_scoreboard.sv
// Directed plus randomized bench for wb_dsp_scoreboard against a queue-based
// reference model of the scoreboard rules.
module tb_wb_dsp_scoreboard;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;

  typedef enum int {M_IDLE, M_RUN, M_PASS, M_FAIL} mode_t;

  logic        wb_clk = 1'b0;
  logic        wb_rst, start, done, exp_valid, meas_valid;
  logic [15:0] exp_tests;
  logic [1:0]  exp_ch, meas_ch;
  logic [31:0] exp_data, meas_data;
  logic        cmp_valid, cmp_pass, busy, test_passed, test_failed;
  logic [1:0]  cmp_ch, fsm_state;
  logic [31:0] cmp_exp, cmp_meas;
  logic [15:0] test_count, err_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0]  mq [NUM_CH][$];
  logic [66:0]  exp_q [$];
  mode_t        m_mode = M_IDLE;
  int           m_tests = 0, m_errs = 0, m_idle = 0;
  logic         m_cmp_vis = 1'b0;
  logic         e_cmp_valid = 1'b0;

  wb_dsp_scoreboard #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .done(done), .exp_tests(exp_tests),
    .exp_valid(exp_valid), .exp_ch(exp_ch), .exp_data(exp_data),
    .meas_valid(meas_valid), .meas_ch(meas_ch), .meas_data(meas_data),
    .cmp_valid(cmp_valid), .cmp_pass(cmp_pass), .cmp_ch(cmp_ch), .cmp_exp(cmp_exp),
    .cmp_meas(cmp_meas), .test_count(test_count), .err_count(err_count), .busy(busy),
    .test_passed(test_passed), .test_failed(test_failed), .fsm_state(fsm_state)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  function automatic bit all_empty();
    for (int c = 0; c < NUM_CH; c++) if (mq[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Applies the scoreboard rules to one clock edge worth of inputs.
  task automatic model_edge(input logic r, input logic st, input logic dn,
                            input logic ev, input logic [1:0] ec, input logic [31:0] ed,
                            input logic mv, input logic [1:0] mc, input logic [31:0] md,
                            input logic [15:0] et);
    logic        proto;
    logic [31:0] h;
    logic        p;
    proto = 1'b0;
    e_cmp_valid = 1'b0;
    if (r || st) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      m_mode = r ? M_IDLE : M_RUN;
      m_tests = 0; m_errs = 0; m_idle = 0;
    end else if (m_mode == M_RUN) begin
      m_idle = m_cmp_vis ? 0 : m_idle + 1;
      if (mv) begin
        e_cmp_valid = 1'b1;
        if (mq[mc].size() > 0) begin
          h = mq[mc].pop_front();
          p = (h == md);
          m_tests = sat(m_tests + 1);
          if (!p) m_errs = sat(m_errs + 1);
          exp_q.push_back({p, mc, h, md});
        end else begin
          m_errs = sat(m_errs + 1);
          proto = 1'b1;
          exp_q.push_back({1'b0, mc, 32'h0, md});
        end
      end
      if (ev) begin
        if (mq[ec].size() < DEPTH) mq[ec].push_back(ed);
        else begin m_errs = sat(m_errs + 1); proto = 1'b1; end
      end
      if (proto || m_idle == TIMEOUT) m_mode = M_FAIL;
      else if (dn) m_mode = (m_tests == int'(et) && m_errs == 0 && all_empty()) ? M_PASS : M_FAIL;
    end
    m_cmp_vis = e_cmp_valid;
  endtask

  // One clock: model the edge, check every output, then release pulse inputs.
  task automatic tick();
    logic [66:0] rec;
    model_edge(wb_rst, start, done, exp_valid, exp_ch, exp_data,
               meas_valid, meas_ch, meas_data, exp_tests);
    @(posedge wb_clk);
    #1;
    chk("cmp_valid", cmp_valid, e_cmp_valid);
    if (e_cmp_valid) begin
      rec = exp_q.pop_front();
      chk("cmp_record", {cmp_pass, cmp_ch, cmp_exp, cmp_meas}, rec);
    end
    chk("test_count", test_count, m_tests);
    chk("err_count", err_count, m_errs);
    chk("flags", {busy, test_passed, test_failed},
        {m_mode == M_RUN, m_mode == M_PASS, m_mode == M_FAIL});
    wb_rst = 1'b0; start = 1'b0; done = 1'b0; exp_valid = 1'b0; meas_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick();
  endtask

  task automatic push(input logic [1:0] c, input logic [31:0] d);
    exp_valid = 1'b1; exp_ch = c; exp_data = d; tick();
  endtask

  task automatic meas(input logic [1:0] c, input logic [31:0] d);
    meas_valid = 1'b1; meas_ch = c; meas_data = d; tick();
  endtask

  task automatic do_done(input logic [15:0] et);
    exp_tests = et; done = 1'b1; tick(); tick();
  endtask

  initial begin
    logic [31:0] v;
    wb_rst = 1'b1; start = 0; done = 0; exp_valid = 0; meas_valid = 0;
    exp_tests = 0; exp_ch = 0; exp_data = 0; meas_ch = 0; meas_data = 0;
    tick();
    wb_rst = 1'b1; tick();
    chk("reset_cmp_fields", {cmp_pass, cmp_ch, cmp_exp, cmp_meas}, '0);

    // Single matching compare -> PASS
    do_start();
    push(2'd0, 32'hDEADBEEF);
    meas(2'd0, 32'hDEADBEEF);
    chk("t1_pass_strobe", {cmp_valid, cmp_pass}, 2'b11);
    do_done(16'd1);
    chk("t1_passed", test_passed, 1'b1);

    // Mismatch -> FAIL
    do_start();
    push(2'd2, 32'h1);
    meas(2'd2, 32'h2);
    chk("t2_operands", {cmp_pass, cmp_exp, cmp_meas}, {1'b0, 32'h1, 32'h2});
    do_done(16'd1);
    chk("t2_failed", {err_count, test_failed}, {16'd1, 1'b1});

    // Per-channel ordering
    do_start();
    push(2'd1, 32'hA); push(2'd1, 32'hB); push(2'd3, 32'hC);
    meas(2'd3, 32'hC); meas(2'd1, 32'hA); meas(2'd1, 32'hB);
    do_done(16'd3);
    chk("t3_passed", {test_count, test_passed}, {16'd3, 1'b1});

    // Overflow on the ninth push
    do_start();
    for (int i = 0; i < 9; i++) push(2'd0, 32'h100 + i);
    chk("t4_overflow", {err_count, test_failed}, {16'd1, 1'b1});

    // Watchdog
    do_start();
    for (int i = 0; i < 99; i++) tick();
    chk("t5_before_timeout", test_failed, 1'b0);
    tick();
    chk("t5_at_timeout", test_failed, 1'b1);

    // Reset mid-run with entries queued, then a fresh run
    do_start();
    push(2'd1, 32'h11); push(2'd1, 32'h22); push(2'd2, 32'h33);
    wb_rst = 1'b1; tick();
    chk("t6_reset_all", {cmp_valid, cmp_pass, cmp_ch, cmp_exp, cmp_meas, test_count,
        err_count, busy, test_passed, test_failed}, '0);
    do_start();
    push(2'd1, 32'h5A5A);
    meas(2'd1, 32'h5A5A);
    do_done(16'd1);
    chk("t6_fresh_pass", test_passed, 1'b1);

    // Same-cycle push and measure, empty FIFO -> unexpected
    do_start();
    exp_valid = 1; exp_ch = 2'd2; exp_data = 32'h77;
    meas_valid = 1; meas_ch = 2'd2; meas_data = 32'h77;
    tick();
    chk("t7_unexpected", {cmp_pass, cmp_exp, err_count}, {1'b0, 32'h0, 16'd1});
    tick();
    chk("t7_failed", test_failed, 1'b1);

    // Same-cycle push and measure on a full FIFO -> push accepted
    do_start();
    for (int i = 0; i < DEPTH; i++) push(2'd3, 32'h300 + i);
    exp_valid = 1; exp_ch = 2'd3; exp_data = 32'h3FF;
    meas_valid = 1; meas_ch = 2'd3; meas_data = 32'h300;
    tick();
    for (int i = 1; i < DEPTH; i++) meas(2'd3, 32'h300 + i);
    meas(2'd3, 32'h3FF);
    do_done(16'd9);
    chk("t8_full_pass", {err_count, test_passed}, {16'd0, 1'b1});

    // Randomized runs
    for (int run = 0; run < 8; run++) begin
      do_start();
      for (int i = 0; i < 50; i++) begin
        exp_valid = ($urandom_range(0, 1) == 1);
        exp_ch = 2'($urandom_range(0, 3));
        exp_data = $urandom;
        meas_ch = 2'($urandom_range(0, 3));
        meas_valid = ($urandom_range(0, 2) == 0) &&
                     (mq[meas_ch].size() > 0 || $urandom_range(0, 15) == 0);
        if (mq[meas_ch].size() > 0 && $urandom_range(0, 9) != 0) meas_data = mq[meas_ch][0];
        else meas_data = $urandom;
        tick();
      end
      for (int c = 0; c < NUM_CH; c++) begin
        while (mq[c].size() > 0 && m_mode == M_RUN) begin
          v = mq[c][0];
          meas(2'(c), v);
        end
      end
      do_done(16'(m_tests + (($urandom_range(0, 3) == 0) ? 1 : 0)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
